// File: rtl/vec_pkg.sv
// ---------------------------------------------------------------------------
// vec_pkg -- shared definitions for the vector decode/issue slice.
//
// Purpose : opcode encodings, control-word layout (struct plus bit indices)
//           and a helper that sizes the lane-group beat index.
// Ports   : none (package).
// Config  : VEC_DECODE_ISSUE_SCOREBOARD_EN is consumed by vec_decode_issue,
//           nothing here depends on it.
// ---------------------------------------------------------------------------
package vec_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_VRTYPE = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam int CTRL_W          = 9;
    localparam int CTRL_IS_VEC     = 8;
    localparam int CTRL_REG_DST    = 7;
    localparam int CTRL_ALU_OP_HI  = 6;
    localparam int CTRL_ALU_OP_LO  = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_REG_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    // Field order matches the CTRL_* indices above, MSB first.
    typedef struct packed {
        logic       is_vec;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    // Beat index width; a single-beat configuration still gets one bit.
    function automatic int beat_width(input int nlanes, input int lanes_per_beat);
        int beats;
        beats = nlanes / lanes_per_beat;
        return (beats <= 2) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/vec_decode_issue_if.sv
// ---------------------------------------------------------------------------
// vec_decode_issue_if -- fetch-side, writeback-side and EX-side signals of
// the decode/issue stage.
//
// Parameters : DW     immediate width
//              BEAT_W width of the lane-group beat index
// Modports   : slave  -- the decode/issue stage
//              master -- the environment (fetch buffer, writeback, EX)
// Signals    : in_valid/in_ready/in_instn  instruction handshake
//              flush                       taken branch, kill held instruction
//              wb_valid/wb_vec/wb_addr     register writeback notification
//              out_valid/out_ready         issue handshake
//              out_opcode..out_last        issued fields, controls, beat info
// ---------------------------------------------------------------------------
interface vec_decode_issue_if
    import vec_pkg::*;
#(
    parameter int DW     = 32,
    parameter int BEAT_W = 1
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instn;
    logic              flush;
    logic              wb_valid;
    logic              wb_vec;
    logic [4:0]        wb_addr;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_opcode;
    logic [5:0]        out_funct;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_rd;
    logic [4:0]        out_shamt;
    logic [DW-1:0]     out_immd;
    logic [CTRL_W-1:0] out_ctrl;
    logic [BEAT_W-1:0] out_beat;
    logic              out_last;

    modport slave (
        input  in_valid, in_instn, flush, wb_valid, wb_vec, wb_addr, out_ready,
        output in_ready, out_valid, out_opcode, out_funct, out_rs, out_rt,
               out_rd, out_shamt, out_immd, out_ctrl, out_beat, out_last
    );

    modport master (
        output in_valid, in_instn, flush, wb_valid, wb_vec, wb_addr, out_ready,
        input  in_ready, out_valid, out_opcode, out_funct, out_rs, out_rt,
               out_rd, out_shamt, out_immd, out_ctrl, out_beat, out_last
    );
endinterface

// File: rtl/vec_decode.sv
// ---------------------------------------------------------------------------
// vec_decode -- purely combinational instruction decoder.
//
// Parameters : DW  width of the sign-extended immediate (> 16)
// Ports      : instn   in   32  instruction word
//              opcode  out  6   instn[31:26]
//              rs/rt/rd/shamt out 5, funct out 6
//              immd    out  DW  sign-extended instn[15:0]
//              ctrl    out  ctrl_t control word
//              use_rt  out  1   rt is a true source (R-type, sw, beq)
// ---------------------------------------------------------------------------
module vec_decode
    import vec_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [31:0]   instn,
    output logic [5:0]    opcode,
    output logic [5:0]    funct,
    output logic [4:0]    rs,
    output logic [4:0]    rt,
    output logic [4:0]    rd,
    output logic [4:0]    shamt,
    output logic [DW-1:0] immd,
    output ctrl_t         ctrl,
    output logic          use_rt
);

    assign opcode = instn[31:26];
    assign rs     = instn[25:21];
    assign rt     = instn[20:16];
    assign rd     = instn[15:11];
    assign shamt  = instn[10:6];
    assign funct  = instn[5:0];
    assign immd   = {{(DW-16){instn[15]}}, instn[15:0]};

    always_comb begin
        ctrl   = '0;
        use_rt = 1'b0;
        case (instn[31:26])
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_op    = 2'b10;
                ctrl.reg_write = 1'b1;
                use_rt         = 1'b1;
            end
            OP_VRTYPE: begin
                ctrl.is_vec    = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_op    = 2'b10;
                ctrl.reg_write = 1'b1;
                use_rt         = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                use_rt         = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = 2'b01;
                use_rt      = 1'b1;
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            default: ;  // unknown opcode issues as a nop
        endcase
    end

endmodule

// File: rtl/vec_decode_issue.sv
// ---------------------------------------------------------------------------
// vec_decode_issue -- decode/issue stage between the fetch buffer and EX.
//
// Decodes one instruction, interlocks RAW hazards against a scalar/vector
// scoreboard and issues vector operations as NLANES/LANES_PER_BEAT beats.
//
// Parameters : NLANES          vector lanes (power of two, 2..64)
//              LANES_PER_BEAT  lanes per issued beat (divides NLANES)
//              DW              immediate width
// Ports      : clk   in  clock, rising edge
//              rst   in  asynchronous active-high reset
//              bus   vec_decode_issue_if.slave (BEAT_W must equal
//                    vec_pkg::beat_width(NLANES, LANES_PER_BEAT))
// Config     : VEC_DECODE_ISSUE_SCOREBOARD_EN -- when defined, a scoreboard
//              and hazard interlock are built; otherwise hazard is tied low
//              and the writeback inputs are ignored.
// ---------------------------------------------------------------------------
module vec_decode_issue
    import vec_pkg::*;
#(
    parameter int NLANES         = 8,
    parameter int LANES_PER_BEAT = 8,
    parameter int DW             = 32
) (
    input  logic              clk,
    input  logic              rst,
    vec_decode_issue_if.slave bus
);

    localparam int BEATS  = NLANES / LANES_PER_BEAT;
    localparam int BEAT_W = beat_width(NLANES, LANES_PER_BEAT);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    // Decode (combinational on the incoming word)
    logic [5:0]    dec_opcode;
    logic [5:0]    dec_funct;
    logic [4:0]    dec_rs;
    logic [4:0]    dec_rt;
    logic [4:0]    dec_rd;
    logic [4:0]    dec_shamt;
    logic [DW-1:0] dec_immd;
    ctrl_t         dec_ctrl;
    logic          dec_use_rt;

    vec_decode #(.DW(DW)) u_decode (
        .instn  (bus.in_instn),
        .opcode (dec_opcode),
        .funct  (dec_funct),
        .rs     (dec_rs),
        .rt     (dec_rt),
        .rd     (dec_rd),
        .shamt  (dec_shamt),
        .immd   (dec_immd),
        .ctrl   (dec_ctrl),
        .use_rt (dec_use_rt)
    );

    logic              vld_p1;
    logic [5:0]        opcode_p1;
    logic [5:0]        funct_p1;
    logic [4:0]        rs_p1;
    logic [4:0]        rt_p1;
    logic [4:0]        rd_p1;
    logic [4:0]        shamt_p1;
    logic [DW-1:0]     immd_p1;
    ctrl_t             ctrl_p1;
    logic [BEAT_W-1:0] beat_p1;

    logic [4:0] dest_p1;
    logic       last_p1;
    logic       beat_fire;
    logic       retire;
    logic       hazard;
    logic       in_ready;
    logic       load;

    assign dest_p1   = ctrl_p1.reg_dst ? rd_p1 : rt_p1;
    assign last_p1   = vld_p1 & (~ctrl_p1.is_vec | (beat_p1 == LAST_BEAT));
    assign beat_fire = vld_p1 & bus.out_ready;
    assign retire    = beat_fire & last_p1;

    // A new instruction may enter only when the slot is free or its final
    // beat leaves this cycle; flush kills whatever would have been loaded.
    assign in_ready = ~hazard & (~vld_p1 | (bus.out_ready & last_p1));
    assign load     = bus.in_valid & in_ready & ~bus.flush;

`ifdef VEC_DECODE_ISSUE_SCOREBOARD_EN
    logic [31:0] spend;
    logic [31:0] vpend;
    logic [31:0] wb_onehot;
    logic [31:0] spend_eff;
    logic [31:0] vpend_eff;
    logic [31:0] set_s;
    logic [31:0] set_v;
    logic [31:0] file_pend;
    logic        held_match;
    logic        rs_haz;
    logic        rt_haz;

    // Writeback clears are applied combinationally so an instruction waiting
    // on that register can be accepted in the same cycle.
    always_comb begin
        wb_onehot = 32'd1 << bus.wb_addr;
        spend_eff = spend;
        vpend_eff = vpend;
        if (bus.wb_valid && !bus.wb_vec) spend_eff = spend & ~wb_onehot;
        if (bus.wb_valid &&  bus.wb_vec) vpend_eff = vpend & ~wb_onehot;

        set_s = '0;
        set_v = '0;
        if (retire && !bus.flush && ctrl_p1.reg_write && (dest_p1 != 5'd0)) begin
            if (ctrl_p1.is_vec) set_v = 32'd1 << dest_p1;
            else                set_s = 32'd1 << dest_p1;
        end

        // The held instruction has not set its bit yet, so its destination
        // is compared directly against the incoming sources.
        file_pend  = dec_ctrl.is_vec ? vpend_eff : spend_eff;
        held_match = vld_p1 & ctrl_p1.reg_write & (ctrl_p1.is_vec == dec_ctrl.is_vec)
                   & (dest_p1 != 5'd0);
        rs_haz = (dec_rs != 5'd0) &
                 (file_pend[dec_rs] | (held_match & (dec_rs == dest_p1)));
        rt_haz = dec_use_rt & (dec_rt != 5'd0) &
                 (file_pend[dec_rt] | (held_match & (dec_rt == dest_p1)));
        hazard = rs_haz | rt_haz;
    end

    // Set is OR-ed after the clear so a same-cycle set/clear leaves the bit
    // set; register 0 is masked so it can never stall anything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spend <= '0;
            vpend <= '0;
        end else begin
            spend <= (spend_eff | set_s) & ~32'd1;
            vpend <= (vpend_eff | set_v) & ~32'd1;
        end
    end
`else
    logic unused_sb;

    assign hazard    = 1'b0;
    assign unused_sb = ^{dec_use_rt, bus.wb_valid, bus.wb_vec, bus.wb_addr};
`endif

    // ---- stage p0 -> p1 : issue register and beat counter ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            beat_p1   <= '0;
            opcode_p1 <= '0;
            funct_p1  <= '0;
            rs_p1     <= '0;
            rt_p1     <= '0;
            rd_p1     <= '0;
            shamt_p1  <= '0;
            immd_p1   <= '0;
            ctrl_p1   <= '0;
        end else if (bus.flush) begin
            vld_p1  <= 1'b0;
            beat_p1 <= '0;
        end else if (load) begin
            vld_p1    <= 1'b1;
            beat_p1   <= '0;
            opcode_p1 <= dec_opcode;
            funct_p1  <= dec_funct;
            rs_p1     <= dec_rs;
            rt_p1     <= dec_rt;
            rd_p1     <= dec_rd;
            shamt_p1  <= dec_shamt;
            immd_p1   <= dec_immd;
            ctrl_p1   <= dec_ctrl;
        end else if (retire) begin
            vld_p1  <= 1'b0;
            beat_p1 <= '0;
        end else if (beat_fire) begin
            beat_p1 <= beat_p1 + BEAT_W'(1);
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = vld_p1;
    assign bus.out_opcode = opcode_p1;
    assign bus.out_funct  = funct_p1;
    assign bus.out_rs     = rs_p1;
    assign bus.out_rt     = rt_p1;
    assign bus.out_rd     = rd_p1;
    assign bus.out_shamt  = shamt_p1;
    assign bus.out_immd   = immd_p1;
    assign bus.out_ctrl   = ctrl_p1;
    assign bus.out_beat   = beat_p1;
    assign bus.out_last   = last_p1;

endmodule

// File: tb/tb_vec_decode_issue.sv
// ---------------------------------------------------------------------------
// tb_vec_decode_issue -- directed self-checking bench for vec_decode_issue
// configured with NLANES=8, LANES_PER_BEAT=2 (four beats per vector op).
// Expectations that depend on VEC_DECODE_ISSUE_SCOREBOARD_EN follow SB.
// ---------------------------------------------------------------------------
module tb_vec_decode_issue;

`ifdef VEC_DECODE_ISSUE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    vec_decode_issue_if #(.DW(32), .BEAT_W(2)) bus ();

    vec_decode_issue #(
        .NLANES         (8),
        .LANES_PER_BEAT (2),
        .DW             (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_instn  = 32'h0;
        bus.flush     = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_vec    = 1'b0;
        bus.wb_addr   = 5'd0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", bus.out_valid); else passed++;
        total++; if (bus.out_ctrl !== 9'h000) $display("FAIL reset_ctrl got=%h want=000", bus.out_ctrl); else passed++;
        total++; if (bus.out_beat !== 2'd0) $display("FAIL reset_beat got=%0d want=0", bus.out_beat); else passed++;
        total++; if (bus.out_immd !== 32'h0) $display("FAIL reset_immd got=%h want=0", bus.out_immd); else passed++;
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); else passed++;
        // reset in the middle of a vector instruction
        bus.in_valid = 1'b1;
        bus.in_instn = 32'h04221800;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL midrst_loaded got=%0b want=1", bus.out_valid); else passed++;
        tick();
        total++; if (bus.out_beat !== 2'd1) $display("FAIL midrst_beat1 got=%0d want=1", bus.out_beat); else passed++;
        rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid got=%0b want=0", bus.out_valid); else passed++;
        total++; if (bus.out_beat !== 2'd0) $display("FAIL midrst_beat got=%0d want=0", bus.out_beat); else passed++;
        total++; if (bus.out_ctrl !== 9'h000) $display("FAIL midrst_ctrl got=%h want=000", bus.out_ctrl); else passed++;
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready got=%0b want=1", bus.in_ready); else passed++;
    endtask

    task automatic test_scalar_raw();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instn  = 32'h20050001;          // addi r5, r0, 1
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL raw_addi_ready got=%0b want=1", bus.in_ready); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b1) $display("FAIL raw_addi_valid got=%0b want=1", bus.out_valid); else passed++;
        total++; if (bus.out_ctrl !== 9'h012) $display("FAIL raw_addi_ctrl got=%h want=012", bus.out_ctrl); else passed++;
        total++; if (bus.out_rt !== 5'd5) $display("FAIL raw_addi_rt got=%0d want=5", bus.out_rt); else passed++;
        total++; if (bus.out_immd !== 32'h1) $display("FAIL raw_addi_immd got=%h want=1", bus.out_immd); else passed++;
        bus.in_instn = 32'h00A53020;           // add r6, r5, r5
        #1;
        total++; if (bus.in_ready !== !SB) $display("FAIL raw_held_stall got=%0b want=%0b", bus.in_ready, !SB); else passed++;
        tick();
        total++; if (bus.out_valid !== !SB) $display("FAIL raw_stall_valid got=%0b want=%0b", bus.out_valid, !SB); else passed++;
        total++; if (bus.in_ready !== !SB) $display("FAIL raw_pend_stall got=%0b want=%0b", bus.in_ready, !SB); else passed++;
        bus.wb_valid = 1'b1;
        bus.wb_vec   = 1'b0;
        bus.wb_addr  = 5'd5;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL raw_wb_release got=%0b want=1", bus.in_ready); else passed++;
        tick();
        bus.wb_valid = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL raw_add_valid got=%0b want=1", bus.out_valid); else passed++;
        total++; if (bus.out_ctrl !== 9'h0C2) $display("FAIL raw_add_ctrl got=%h want=0c2", bus.out_ctrl); else passed++;
        total++; if (bus.out_rd !== 5'd6) $display("FAIL raw_add_rd got=%0d want=6", bus.out_rd); else passed++;
        total++; if (bus.out_funct !== 6'h20) $display("FAIL raw_add_funct got=%h want=20", bus.out_funct); else passed++;
        total++; if (bus.out_rs !== 5'd5) $display("FAIL raw_add_rs got=%0d want=5", bus.out_rs); else passed++;
    endtask

    task automatic test_vector_beats();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instn  = 32'h04221800;          // vadd v3, v1, v2
        tick();
        bus.in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            total++; if (bus.out_valid !== 1'b1) $display("FAIL vec_valid beat=%0d got=%0b want=1", b, bus.out_valid); else passed++;
            total++; if (bus.out_beat !== 2'(b)) $display("FAIL vec_beat got=%0d want=%0d", bus.out_beat, b); else passed++;
            total++; if (bus.out_last !== (b == 3)) $display("FAIL vec_last beat=%0d got=%0b want=%0b", b, bus.out_last, (b == 3)); else passed++;
            total++; if (bus.out_ctrl !== 9'h1C2) $display("FAIL vec_ctrl beat=%0d got=%h want=1c2", b, bus.out_ctrl); else passed++;
            total++; if (bus.in_ready !== (b == 3)) $display("FAIL vec_in_ready beat=%0d got=%0b want=%0b", b, bus.in_ready, (b == 3)); else passed++;
            tick();
        end
        total++; if (bus.out_valid !== 1'b0) $display("FAIL vec_done_valid got=%0b want=0", bus.out_valid); else passed++;
        bus.in_valid = 1'b1;
        bus.in_instn = 32'h04632000;           // vadd v4, v3, v3
        #1;
        total++; if (bus.in_ready !== !SB) $display("FAIL vec_vpend_stall got=%0b want=%0b", bus.in_ready, !SB); else passed++;
        bus.in_instn = 32'h00632020;           // add r4, r3, r3 (scalar file)
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL vec_scalar_free got=%0b want=1", bus.in_ready); else passed++;
        bus.in_instn = 32'h04632000;
        bus.wb_valid = 1'b1;
        bus.wb_vec   = 1'b1;
        bus.wb_addr  = 5'd3;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL vec_wb_release got=%0b want=1", bus.in_ready); else passed++;
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instn  = 32'h04221800;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_beat !== 2'd0) $display("FAIL flush_beat0 got=%0d want=0", bus.out_beat); else passed++;
        tick();
        total++; if (bus.out_beat !== 2'd1) $display("FAIL flush_beat1 got=%0d want=1", bus.out_beat); else passed++;
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instn = 32'h20050001;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_valid got=%0b want=0", bus.out_valid); else passed++;
        total++; if (bus.out_beat !== 2'd0) $display("FAIL flush_beat_clr got=%0d want=0", bus.out_beat); else passed++;
        bus.in_valid = 1'b1;
        bus.in_instn = 32'h04632000;           // reads v3, never set
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_no_vpend got=%0b want=1", bus.in_ready); else passed++;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL flush_next_valid got=%0b want=1", bus.out_valid); else passed++;
        total++; if (bus.out_beat !== 2'd0) $display("FAIL flush_next_beat got=%0d want=0", bus.out_beat); else passed++;
        total++; if (bus.out_rd !== 5'd4) $display("FAIL flush_next_rd got=%0d want=4", bus.out_rd); else passed++;
        // flush must also suppress a load that would otherwise be accepted
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instn  = 32'h20050001;
        tick();
        bus.flush    = 1'b1;
        bus.in_instn = 32'h10430000;
        tick();
        bus.flush = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_suppress got=%0b want=0", bus.out_valid); else passed++;
        bus.in_instn = 32'h00A53020;           // reads r5, flushed addi never set it
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_no_spend got=%0b want=1", bus.in_ready); else passed++;
        idle();
    endtask

    task automatic test_set_clear();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_instn = 32'h8C070004;           // lw r7, 4(r0)
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_ctrl !== 9'h013) $display("FAIL lw_ctrl got=%h want=013", bus.out_ctrl); else passed++;
        total++; if (bus.out_immd !== 32'h4) $display("FAIL lw_immd got=%h want=4", bus.out_immd); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b1) $display("FAIL lw_hold_valid got=%0b want=1", bus.out_valid); else passed++;
        total++; if (bus.out_rt !== 5'd7) $display("FAIL lw_hold_rt got=%0d want=7", bus.out_rt); else passed++;
        total++; if (bus.out_opcode !== 6'h23) $display("FAIL lw_hold_opcode got=%h want=23", bus.out_opcode); else passed++;
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd7;
        tick();
        bus.out_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL lw_retired got=%0b want=0", bus.out_valid); else passed++;
        bus.in_valid = 1'b1;
        bus.in_instn = 32'h20E80001;           // addi r8, r7, 1
        #1;
        total++; if (bus.in_ready !== !SB) $display("FAIL setwins_stall got=%0b want=%0b", bus.in_ready, !SB); else passed++;
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instn  = 32'h2001FFFF;          // addi r1, r0, -1
        tick();
        total++; if (bus.out_immd !== 32'hFFFFFFFF) $display("FAIL b2b_sext got=%h want=ffffffff", bus.out_immd); else passed++;
        total++; if (bus.out_last !== 1'b1) $display("FAIL b2b_scalar_last got=%0b want=1", bus.out_last); else passed++;
        bus.in_instn = 32'h10430000;           // beq r2, r3
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready got=%0b want=1", bus.in_ready); else passed++;
        tick();
        total++; if (bus.out_ctrl !== 9'h028) $display("FAIL b2b_beq_ctrl got=%h want=028", bus.out_ctrl); else passed++;
        total++; if (bus.out_rs !== 5'd2 || bus.out_rt !== 5'd3) $display("FAIL b2b_beq_regs got=%0d,%0d want=2,3", bus.out_rs, bus.out_rt); else passed++;
        bus.in_instn = 32'hFC000000;           // undefined opcode
        tick();
        total++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_nop_valid got=%0b want=1", bus.out_valid); else passed++;
        total++; if (bus.out_ctrl !== 9'h000) $display("FAIL b2b_nop_ctrl got=%h want=000", bus.out_ctrl); else passed++;
        total++; if (bus.out_opcode !== 6'h3F) $display("FAIL b2b_nop_opcode got=%h want=3f", bus.out_opcode); else passed++;
        bus.in_instn = 32'hACA40008;           // sw r4, 8(r5)
        tick();
        total++; if (bus.out_ctrl !== 9'h014) $display("FAIL b2b_sw_ctrl got=%h want=014", bus.out_ctrl); else passed++;
        total++; if (bus.out_immd !== 32'h8) $display("FAIL b2b_sw_immd got=%h want=8", bus.out_immd); else passed++;
        bus.in_valid = 1'b0;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got=%0b want=0", bus.out_valid); else passed++;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_scalar_raw();
        test_vector_beats();
        test_flush();
        test_set_clear();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vec_decode_issue.md
# vec_decode_issue

Parametrised decode/issue stage for the vector processor, the successor to the fixed 8-lane ID stage. Decodes a 32-bit instruction into fields and control lines, interlocks read-after-write hazards on scalar and vector registers with a scoreboard, and issues vector operations as multi-beat lane groups over a valid/ready handshake to EX. It sits between the fetch buffer and the EX stage. Register-file reads stay outside this block, driven from the issued address fields.

## Interface
- NLANES, 8: vector lanes; power of two, 2..64
- LANES_PER_BEAT, 8: lanes issued per beat; divides NLANES
- DW, 32: data width of the sign-extended immediate
- clk  input  1  single clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  instruction valid
- in_ready  output  1  stage accepts instruction
- in_instn  input  32  instruction word
- flush  input  1  taken branch; kill held instruction
- wb_valid  input  1  writeback occurs
- wb_vec  input  1  writeback targets vector file
- wb_addr  input  5  writeback register
- out_valid  output  1  issue slot valid
- out_ready  input  1  EX accepts beat
- out_opcode / out_funct  output  6 each
- out_rs, out_rt, out_rd, out_shamt  output  5 each
- out_immd  output  DW  sign-extended instn[15:0]
- out_ctrl  output  9  {is_vec, reg_dst, alu_op[1:0], alu_src, branch, mem_write, reg_write, mem_to_reg}
- out_beat  output  $clog2(NLANES/LANES_PER_BEAT) (min 1)  lane-group index
- out_last  output  1  final beat of the instruction

## Operation
- Fields: rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
- Decode by opcode:
  - 0x00 scalar R-type: reg_dst, alu_op=10, reg_write
  - 0x01 vector R-type: same controls plus is_vec
  - 0x23 lw: alu_src, reg_write, mem_to_reg
  - 0x2B sw: alu_src, mem_write
  - 0x04 beq: branch, alu_op=01
  - 0x08 addi: alu_src, reg_write
  - any other opcode: ctrl all zero (nop)
- Destination register: rd if reg_dst, else rt.
- Sources: rs and rt; rt is checked only for R-type, sw and beq.
- Scoreboard: spend[31:0] and vpend[31:0]. Register 0 is never pending.
- Set: on the accepted last beat of a reg_write instruction.
- Clear: on wb_valid into the file selected by wb_vec.
- Same register set and cleared in one cycle: set wins.
- Hazard: a source is pending in the file selected by is_vec, or it matches the held instruction's destination in the same file.
- in_ready = ~hazard & (~out_valid | (out_ready & out_last)).
- Beats: BEATS = NLANES/LANES_PER_BEAT.
  - Scalar instruction: one beat, out_last=1.
  - Vector instruction: BEATS handshakes; out_beat counts 0..BEATS-1; out_last is asserted when out_beat = BEATS-1.
- flush: clears out_valid and out_beat next edge, sets no scoreboard bit, and suppresses any same-cycle load into the output register.

## Timing
- Reset: out_valid=0, out_beat=0, all out_* fields and out_ctrl=0, spend=vpend=0. in_ready is 1 after reset (no hazard).
- Accepted instruction appears on out_* the next cycle (latency 1).
- out_* hold stable while out_valid & ~out_ready.
- Back-to-back scalar issue at 1/cycle when hazard-free.
- A beat is accepted in a cycle with out_valid & out_ready.
- A writeback that clears a hazard allows acceptance in the same cycle (clear is combinationally visible to the hazard check).
- Reset mid-vector: outputs return to reset values immediately.

## Configuration
- VEC_DECODE_ISSUE_SCOREBOARD_EN defined: scoreboard and hazard interlock as above.
- Not defined: no scoreboard registers and hazard=0; software schedules. wb_* ports are present but ignored.

## Structure
- Shared package vec_pkg: opcode localparams, ctrl bit-index constants, ctrl struct/width.
- Sub-module vec_decode: purely combinational instn -> fields + ctrl.
- Top holds the output register, beat counter and scoreboard.

## Test plan
- Reset: assert rst mid-run -> out_valid=0, out_ctrl=0, in_ready=1 on deassert.
- Scalar RAW: issue addi r5 (0x20050001), then add r6,r5,r5 with no writeback -> in_ready=0. wb_valid, wb_addr=5, wb_vec=0 -> accepted that cycle; out_valid next cycle.
- Vector beats: NLANES=8, LANES_PER_BEAT=2, opcode 0x01 with out_ready=1 -> 4 beats, out_beat 0,1,2,3, out_last only on beat 3, then vpend[rd]=1.
- Flush mid-vector after beat 1 -> out_valid=0 next cycle; vpend unchanged; next instruction issues at out_beat=0.
- Same-cycle set/clear on r7: last beat of lw r7 with wb r7 -> spend[7]=1.
- Macro undefined: dependent add follows addi back-to-back with no stall.
